// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// EX owns the master side (operands, start, annul); the divider owns the slave side.
interface div_unit_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider serving the EX-stage DIV/DIVU handshake.
// Returns {remainder, quotient}; divide-by-zero yields all zeros.
// Optional macro DIV_EARLY_EXIT_EN: when |divisor| > |dividend| the result
// {dividend, 0} is produced on the short two-edge path instead of iterating.
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave div_if
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    // StByZero is the one-cycle short path; it also carries early-exit results.
    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_work;     // {partial remainder, dividend/quotient bits}
    logic [DATA_W-1:0]   r_divisor;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*DATA_W-1:0] r_result;   // final value waiting to be exposed in END
    logic [2*DATA_W-1:0] r_result_o;
    logic                r_ready_o;

    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W-1:0] w_next;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    // Operand magnitudes, one restoring step, and the final sign correction.
    always_comb begin
        w_neg_a = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
        w_neg_b = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
        w_mag_a = w_neg_a ? (~div_if.opdata1_i + DATA_W'(1)) : div_if.opdata1_i;
        w_mag_b = w_neg_b ? (~div_if.opdata2_i + DATA_W'(1)) : div_if.opdata2_i;
        // Upper DATA_W+1 bits after the left shift, minus the divisor.
        w_trial = r_work[2*DATA_W-1:DATA_W-1] - {1'b0, r_divisor};
        w_next  = w_trial[DATA_W] ? {r_work[2*DATA_W-2:0], 1'b0}
                                  : {w_trial[DATA_W-1:0], r_work[DATA_W-2:0], 1'b1};
        w_quot  = r_neg_q ? (~r_work[DATA_W-1:0] + DATA_W'(1)) : r_work[DATA_W-1:0];
        w_rem   = r_neg_r ? (~r_work[2*DATA_W-1:DATA_W] + DATA_W'(1))
                          : r_work[2*DATA_W-1:DATA_W];
    end

    // Control FSM with registered result/ready outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StFree;
            r_cnt      <= '0;
            r_work     <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= '0;
            r_result_o <= '0;
            r_ready_o  <= 1'b0;
        end else begin
            case (r_state)
                StFree: begin
                    r_ready_o  <= 1'b0;
                    r_result_o <= '0;
                    r_cnt      <= '0;
                    if (div_if.start_i && !div_if.annul_i) begin
                        r_work    <= {{DATA_W{1'b0}}, w_mag_a};
                        r_divisor <= w_mag_b;
                        r_neg_q   <= w_neg_a ^ w_neg_b;
                        r_neg_r   <= w_neg_a;
                        if (div_if.opdata2_i == '0) begin
                            r_result <= '0;
                            r_state  <= StByZero;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        else if (w_mag_b > w_mag_a) begin
                            // Quotient is zero, remainder is the untouched dividend.
                            r_result <= {div_if.opdata1_i, {DATA_W{1'b0}}};
                            r_state  <= StByZero;
                        end
`endif
                        else begin
                            r_state <= StOn;
                        end
                    end
                end
                StByZero: begin
                    r_state <= StEnd;
                end
                StOn: begin
                    if (div_if.annul_i) begin
                        r_state <= StFree;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(DATA_W)) begin
                        r_result <= {w_rem, w_quot};
                        r_state  <= StEnd;
                        r_cnt    <= '0;
                    end else begin
                        r_work <= w_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                StEnd: begin
                    // Hold the result until EX drops start; annul has no effect here.
                    if (div_if.start_i) begin
                        r_ready_o  <= 1'b1;
                        r_result_o <= r_result;
                    end else begin
                        r_state    <= StFree;
                        r_ready_o  <= 1'b0;
                        r_result_o <= '0;
                    end
                end
                default: begin
                    r_state <= StFree;
                end
            endcase
        end
    end

    assign div_if.result_o = r_result_o;
    assign div_if.ready_o  = r_ready_o;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// overflow, annul, start/annul collision and asynchronous reset.
module tb_div_unit;
    localparam int unsigned DATA_W = 32;
`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_EARLY = 2;
`else
    localparam int LAT_EARLY = 34;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic seen_ready;

    div_unit_if #(.DATA_W(DATA_W)) div_if ();

    div_unit #(.DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (div_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready_o rises (bounded) and checks that count.
    task automatic wait_ready(input string tag, input int lat);
        int n;
        n = 0;
        while (div_if.ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "/latency"}, 64'(n), 64'(lat));
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic [63:0] res,
                           input int hold);
        div_if.signed_div_i = sgn;
        div_if.opdata1_i    = a;
        div_if.opdata2_i    = b;
        div_if.annul_i      = 1'b0;
        div_if.start_i      = 1'b1;
        tick();
        chk({tag, "/accept_ready"}, 64'(div_if.ready_o), 64'd0);
        // Operand changes after acceptance must not matter.
        div_if.opdata1_i    = 32'hDEAD_BEEF;
        div_if.opdata2_i    = 32'h0;
        div_if.signed_div_i = ~sgn;
        wait_ready(tag, lat);
        chk({tag, "/result"}, div_if.result_o, res);
        for (int i = 0; i < hold; i++) begin
            div_if.annul_i = 1'b1;
            tick();
            chk({tag, "/hold_ready"}, 64'(div_if.ready_o), 64'd1);
            chk({tag, "/hold_result"}, div_if.result_o, res);
        end
        div_if.annul_i = 1'b0;
        div_if.start_i = 1'b0;
        tick();
        chk({tag, "/release_ready"}, 64'(div_if.ready_o), 64'd0);
        chk({tag, "/release_result"}, div_if.result_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst                 = 1'b0;
        div_if.start_i      = 1'b0;
        div_if.annul_i      = 1'b0;
        div_if.signed_div_i = 1'b0;
        div_if.opdata1_i    = '0;
        div_if.opdata2_i    = '0;
        #3;
        chk("reset/ready", 64'(div_if.ready_o), 64'd0);
        chk("reset/result", div_if.result_o, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_reset/ready", 64'(div_if.ready_o), 64'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 2);
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 64'hFFFFFFFF_FFFFFFFD, 0);
        run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 34, 64'h00000001_7FFFFFFC, 0);
        run_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 64'h00000001_FFFFFFFD, 0);
        run_div("s_div0", 1'b1, 32'd123, 32'd0, 2, 64'd0, 1);
        run_div("u_div0", 1'b0, 32'hFFFF_FFFF, 32'd0, 2, 64'd0, 0);
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 64'h00000000_80000000, 0);
        run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, LAT_EARLY,
                64'h80000000_00000000, 0);
        run_div("u5_9", 1'b0, 32'd5, 32'd9, LAT_EARLY, 64'h00000005_00000000, 0);
        run_div("s_m5_9", 1'b1, 32'hFFFF_FFFB, 32'd9, LAT_EARLY, 64'hFFFFFFFB_00000000, 0);

        // start and annul together in FREE: not accepted, so the next accept is the real one.
        div_if.signed_div_i = 1'b0;
        div_if.opdata1_i    = 32'd10;
        div_if.opdata2_i    = 32'd2;
        div_if.start_i      = 1'b1;
        div_if.annul_i      = 1'b1;
        tick();
        chk("collide/ready", 64'(div_if.ready_o), 64'd0);
        run_div("u10_2_after_collide", 1'b0, 32'd10, 32'd2, 34, 64'h00000000_00000005, 0);

        // Annul on the 10th ON cycle, then an immediate new request.
        div_if.signed_div_i = 1'b0;
        div_if.opdata1_i    = 32'd1000;
        div_if.opdata2_i    = 32'd3;
        div_if.start_i      = 1'b1;
        div_if.annul_i      = 1'b0;
        seen_ready          = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
            seen_ready = seen_ready | div_if.ready_o;
        end
        div_if.annul_i = 1'b1;
        tick();
        seen_ready = seen_ready | div_if.ready_o;
        chk("annul/ready_never", 64'(seen_ready), 64'd0);
        chk("annul/result", div_if.result_o, 64'd0);
        run_div("u9_3_after_annul", 1'b0, 32'd9, 32'd3, 34, 64'h00000000_00000003, 0);

        // Reset while ON at counter 20, then a normal request.
        div_if.opdata1_i = 32'd1000;
        div_if.opdata2_i = 32'd3;
        div_if.start_i   = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        #2;
        rst            = 1'b0;
        div_if.start_i = 1'b0;
        #1;
        chk("rst_on/ready", 64'(div_if.ready_o), 64'd0);
        chk("rst_on/result", div_if.result_o, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        run_div("u50_5_after_rst", 1'b0, 32'd50, 32'd5, 34, 64'h00000000_0000000A, 0);

        // Reset while a result is exposed must clear outputs without a clock edge.
        div_if.signed_div_i = 1'b0;
        div_if.opdata1_i    = 32'd9;
        div_if.opdata2_i    = 32'd3;
        div_if.start_i      = 1'b1;
        tick();
        wait_ready("rst_end", 34);
        chk("rst_end/result_before", div_if.result_o, 64'h00000000_00000003);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_end/ready_async", 64'(div_if.ready_o), 64'd0);
        chk("rst_end/result_async", div_if.result_o, 64'd0);
        div_if.start_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_end/ready_after", 64'(div_if.ready_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider. It is the responder to the execute stage's DIV/DIVU request handshake.
- EX drives operands, signedness, start and annul; this block iterates one quotient bit per cycle and returns a 64-bit {remainder, quotient}.
- EX writes that result to HI/LO through its existing whilo_o/hi_o/lo_o path, and stalls the pipeline while waiting.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request from EX; held high until ready_o is seen.
- annul_i  in  1  cancel the request in flight (flush / branch kill).
- result_o  out  64  [63:32] remainder (to HI), [31:0] quotient (to LO); registered.
- ready_o  out  1  result_o is valid; registered.

Behaviour:
- Reset (rst=0, async): state=FREE, iteration counter=0, result_o=0, ready_o=0, internal operand registers=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0 at edge N0 -> latch operands and signedness.
  - divisor==0 -> BYZERO; otherwise -> ON with counter=0.
  - Signed mode: negative operands are converted to magnitude (two's complement) at latch.
  - ready_o=0 and result_o=0 in FREE.
- BYZERO: next edge -> END with latched result {0,0}. MIPS leaves this undefined; we fix it to 0.
- ON:
  - Radix-2 restoring step per edge on a 65-bit shift register: shift left 1, trial-subtract divisor from the upper 33 bits, set the quotient bit if the result is non-negative.
  - Counter increments 0..31 at edges N0+1..N0+32.
  - At edge N0+33 (counter==32), apply sign fix and go to END.
  - Sign fix (signed only): negate quotient if dividend sign XOR divisor sign; remainder takes the dividend's sign.
  - annul_i=1 at any edge in ON -> FREE, counter=0, result_o stays 0, ready_o stays 0.
  - Operand or start_i changes during ON are ignored.
- END:
  - Entry edge (N0+34 for normal divide, N0+2 for BYZERO) registers result_o and sets ready_o=1.
  - Stays in END while start_i=1; annul_i is ignored in END.
  - At the first edge with start_i=0 -> FREE, ready_o=0, result_o=0.
  - A new request therefore requires at least one start_i-low cycle.
- Latency, start accepted to ready_o high: 34 edges normal, 2 edges for divide-by-zero.
- Overflow case (signed 0x80000000 / 0xFFFFFFFF): quotient wraps to 0x80000000, remainder 0. No exception is raised.
- Simultaneous start_i and annul_i in FREE: request is not accepted.
- rst asserted mid-operation: immediate return to FREE with all outputs 0. No partial result is ever exposed.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined:
  - In FREE, if divisor≠0 and |divisor| > |dividend| (magnitudes after sign handling), skip ON and go directly to END.
  - Result is quotient=0, remainder=original dividend (sign preserved).
  - Latency is 2 edges, same as BYZERO.
  - Annul and reset rules are unchanged.
- Undefined: every nonzero-divisor request takes the full 34-edge path. Results are bit-identical either way.

Test Plan:
- Unsigned 100/7, start held high -> ready_o rises exactly 34 edges after accept; result_o=0x00000002_0000000E.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). Unsigned same operands -> quot 0x7FFFFFFC, rem 1.
- Divisor 0, either mode -> ready_o high 2 edges after accept; result_o=0. Drop start_i -> FREE next edge, ready_o=0.
- Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. Unsigned same operands -> result_o=0x80000000_00000000.
- Start 1000/3, assert annul_i on the 10th ON cycle -> FREE next edge, ready_o never asserts. Immediate new request 9/3 -> result_o=0x00000000_00000003 after 34 edges.
- Pull rst low for one cycle at ON counter=20 -> outputs 0 asynchronously, state FREE. Next request 50/5 completes normally with quotient 10, remainder 0.
